// File: rtl/pe_pkg.sv
// Shared types and default widths for the systolic-array processing elements.
//   acc_sel_e          : accumulator base select encoding
//   DefInDataWidth     : default signed operand element width
//   DefOutDataWidth    : default accumulator width
package pe_pkg;

  localparam int unsigned DefInDataWidth  = 8;
  localparam int unsigned DefOutDataWidth = 32;
  localparam int unsigned AccSelWidth     = 2;

  // Accumulator base: keep own value, chain from a neighbour, or clear.
  typedef enum logic [AccSelWidth-1:0] {
    ACC_SELF  = 2'd0,
    ACC_NORTH = 2'd1,
    ACC_WEST  = 2'd2,
    ACC_ZERO  = 2'd3
  } acc_sel_e;

endpackage : pe_pkg

// File: rtl/mac_dot.sv
// Combinational signed dot product of NumInputs operand pairs.
//   a, b : packed signed operand vectors [NumInputs-1:0][InDataWidth-1:0]
//   dot_c: sum of element products, sign-extended/truncated to OutDataWidth
module mac_dot
  import pe_pkg::*;
#(
  parameter int unsigned InDataWidth  = DefInDataWidth,
  parameter int unsigned NumInputs    = 1,
  parameter int unsigned OutDataWidth = DefOutDataWidth
) (
  input  logic [NumInputs-1:0][InDataWidth-1:0] a,
  input  logic [NumInputs-1:0][InDataWidth-1:0] b,
  output logic [OutDataWidth-1:0]               dot_c
);

  localparam int unsigned ProdWidth = 2 * InDataWidth;

  logic signed [ProdWidth-1:0]    prod;
  logic signed [OutDataWidth-1:0] sum;

  // Each product is sign-extended (or truncated) to the accumulator width
  // before summing, so the total wraps modulo 2^OutDataWidth.
  always_comb begin
    prod = '0;
    sum  = '0;
    for (int unsigned i = 0; i < NumInputs; i++) begin
      prod = $signed(a[i]) * $signed(b[i]);
      sum  = sum + OutDataWidth'(prod);
    end
  end

  assign dot_c = sum;

endmodule : mac_dot

// File: rtl/mac_pe_general.sv
// Signed multiply-accumulate PE for a 2-D systolic array.
//   clk_i, rst_ni        : clock, async active-low reset
//   a_i/b_i, *_valid_i   : operand vectors and their valids
//   acc_north, acc_west  : neighbour partial sums
//   acc_mux_sel          : accumulator base select (pe_pkg::acc_sel_e)
//   a_o_east, b_o_south  : registered operands forwarded to neighbours
//   acc_east, acc_south  : accumulator register (same value on both)
module mac_pe_general
  import pe_pkg::*;
#(
  parameter int unsigned InDataWidth  = DefInDataWidth,
  parameter int unsigned NumInputs    = 1,
  parameter int unsigned OutDataWidth = DefOutDataWidth
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic [NumInputs-1:0][InDataWidth-1:0] a_i,
  input  logic [NumInputs-1:0][InDataWidth-1:0] b_i,
  input  logic                                 a_valid_i,
  input  logic                                 b_valid_i,
  input  logic [OutDataWidth-1:0]              acc_north,
  input  logic [OutDataWidth-1:0]              acc_west,
  input  logic [AccSelWidth-1:0]               acc_mux_sel,
  output logic [NumInputs-1:0][InDataWidth-1:0] a_o_east,
  output logic [NumInputs-1:0][InDataWidth-1:0] b_o_south,
  output logic [OutDataWidth-1:0]              acc_east,
  output logic [OutDataWidth-1:0]              acc_south
);

  logic [NumInputs-1:0][InDataWidth-1:0] a_reg;
  logic [NumInputs-1:0][InDataWidth-1:0] b_reg;
  logic                                  v_reg;
  logic [OutDataWidth-1:0]               acc;
  logic [OutDataWidth-1:0]               dot;
  logic [OutDataWidth-1:0]               pv;
  logic [OutDataWidth-1:0]               base;
  logic [OutDataWidth-1:0]               acc_d;
  logic                                  clr;
  acc_sel_e                              sel;

  // Stage 1: operand capture; pairs only count when both sides were valid.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_reg <= '0;
      b_reg <= '0;
      v_reg <= 1'b0;
    end else begin
      if (a_valid_i) a_reg <= a_i;
      if (b_valid_i) b_reg <= b_i;
      v_reg <= a_valid_i & b_valid_i;
    end
  end

  mac_dot #(
    .InDataWidth (InDataWidth),
    .NumInputs   (NumInputs),
    .OutDataWidth(OutDataWidth)
  ) u_dot (
    .a    (a_reg),
    .b    (b_reg),
    .dot_c(dot)
  );

  assign pv  = v_reg ? dot : '0;
  assign sel = acc_sel_e'(acc_mux_sel);

  // Accumulator base mux; clear ignores the product entirely.
  always_comb begin
    base = '0;
    clr  = 1'b0;
    unique case (sel)
      ACC_SELF:  base = acc;
      ACC_NORTH: base = acc_north;
      ACC_WEST:  base = acc_west;
      ACC_ZERO:  clr  = 1'b1;
      default:   clr  = 1'b1;
    endcase
    acc_d = clr ? '0 : base + pv;
  end

  // Stage 2: accumulator, updated every edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc <= '0;
    else         acc <= acc_d;
  end

  assign a_o_east  = a_reg;
  assign b_o_south = b_reg;
  assign acc_east  = acc;
  assign acc_south = acc;

endmodule : mac_pe_general

// File: tb/tb_mac_pe_general.sv
// Directed self-checking bench for mac_pe_general (NumInputs=1 and 4).
module tb_mac_pe_general;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // NumInputs = 1 instance
  logic [0:0][7:0] a1, b1, ao1, bo1;
  logic            av1, bv1;
  logic [31:0]     north1, west1, ae1, as1;
  logic [1:0]      sel1;

  // NumInputs = 4 instance
  logic [3:0][7:0] a4, b4, ao4, bo4;
  logic            av4, bv4;
  logic [31:0]     north4, west4, ae4, as4;
  logic [1:0]      sel4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mac_pe_general #(.InDataWidth(8), .NumInputs(1), .OutDataWidth(32)) u_pe1 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a1), .b_i(b1),
    .a_valid_i(av1), .b_valid_i(bv1), .acc_north(north1), .acc_west(west1),
    .acc_mux_sel(sel1), .a_o_east(ao1), .b_o_south(bo1),
    .acc_east(ae1), .acc_south(as1)
  );

  mac_pe_general #(.InDataWidth(8), .NumInputs(4), .OutDataWidth(32)) u_pe4 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a4), .b_i(b4),
    .a_valid_i(av4), .b_valid_i(bv4), .acc_north(north4), .acc_west(west4),
    .acc_mux_sel(sel4), .a_o_east(ao4), .b_o_south(bo4),
    .acc_east(ae4), .acc_south(as4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before sampling and changing inputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_acc1(input string tag, input logic [31:0] exp);
    check({tag, "_east"},  64'(ae1), 64'(exp));
    check({tag, "_south"}, 64'(as1), 64'(exp));
  endtask

  initial begin
    a1 = '0; b1 = '0; av1 = 1'b0; bv1 = 1'b0; north1 = '0; west1 = '0; sel1 = 2'b00;
    a4 = '0; b4 = '0; av4 = 1'b0; bv4 = 1'b0; north4 = '0; west4 = '0; sel4 = 2'b00;

    // 1. Reset for 4 cycles, outputs zero during and after.
    repeat (4) step();
    check("rst_a_o",   64'(ao1), 64'h0);
    check("rst_b_o",   64'(bo1), 64'h0);
    check_acc1("rst_acc", 32'h0);
    rst_n = 1'b1;
    repeat (3) step();
    check_acc1("idle_acc", 32'h0);
    check("idle_acc4", 64'(ae4), 64'h0);

    // 2. a=-1, b=10 held for two edges: first product lands on edge 2.
    a1 = 8'hFF; b1 = 8'd10; av1 = 1'b1; bv1 = 1'b1;
    step();
    step();
    check("t2_a_o", 64'(ao1), 64'hFF);
    check("t2_b_o", 64'(bo1), 64'd10);
    check_acc1("t2_acc", 32'hFFFF_FFF6);
    av1 = 1'b0; bv1 = 1'b0;
    step();   // second held edge's product is added too
    check_acc1("t2_acc_twice", 32'hFFFF_FFEC);

    // 3. Clear.
    sel1 = 2'b11;
    step();
    check_acc1("t3_clr", 32'h0);

    // 4. Load from north, then west, then clear.
    sel1 = 2'b01; north1 = 32'h1234_5678;
    step();
    check_acc1("t4_north", 32'h1234_5678);
    sel1 = 2'b10; west1 = 32'hDEAD_BEEF;
    step();
    check_acc1("t4_west", 32'hDEAD_BEEF);
    sel1 = 2'b11;
    step();
    check_acc1("t4_clr", 32'h0);

    // 5. Accumulate 3*4 then -2*5.
    sel1 = 2'b00;
    a1 = 8'd3; b1 = 8'd4; av1 = 1'b1; bv1 = 1'b1;
    step();
    a1 = 8'hFE; b1 = 8'd5;
    step();
    check_acc1("t5_acc12", 32'd12);
    av1 = 1'b0; bv1 = 1'b0;
    step();
    check_acc1("t5_acc2", 32'd2);

    // Wrap: 0x7FFFFFFF + 1*1.
    sel1 = 2'b01; north1 = 32'h7FFF_FFFF;
    step();
    check_acc1("t5_load", 32'h7FFF_FFFF);
    sel1 = 2'b00; a1 = 8'd1; b1 = 8'd1; av1 = 1'b1; bv1 = 1'b1;
    step();
    av1 = 1'b0; bv1 = 1'b0;
    step();
    check_acc1("t5_wrap", 32'h8000_0000);

    // b valid alone: b_reg moves, accumulator does not.
    b1 = 8'd7; bv1 = 1'b1;
    step();
    bv1 = 1'b0;
    check("t5_bonly_b_o", 64'(bo1), 64'd7);
    check("t5_bonly_a_o", 64'(ao1), 64'd1);
    step();
    check_acc1("t5_bonly_acc", 32'h8000_0000);

    // 6. Four-way dot product: {1,2,3,4} . {-1,-1,-1,-1} = -10.
    a4 = 32'h0102_0304; b4 = 32'hFFFF_FFFF; av4 = 1'b1; bv4 = 1'b1;
    step();
    av4 = 1'b0; bv4 = 1'b0;
    step();
    check("t6_acc_east",  64'(ae4), 64'hFFFF_FFF6);
    check("t6_acc_south", 64'(as4), 64'hFFFF_FFF6);
    check("t6_b_o",       64'(bo4), 64'hFFFF_FFFF);
    a4 = 32'h0506_0708; av4 = 1'b1;
    step();
    av4 = 1'b0;
    check("t6_aonly_a_o", 64'(ao4), 64'h0506_0708);
    step();
    check("t6_aonly_acc", 64'(ae4), 64'hFFFF_FFF6);

    // Asynchronous reset mid-operation, checked between edges.
    #2 rst_n = 1'b0;
    #1;
    check("arst_acc1", 64'(ae1), 64'h0);
    check("arst_acc4", 64'(as4), 64'h0);
    check("arst_a_o4", 64'(ao4), 64'h0);
    check("arst_b_o1", 64'(bo1), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_mac_pe_general
